// File: rtl/program_loader_if.sv
// Byte-stream input and memory/status output bundle of the program loader.
// The loader side uses the slave modport; the feeding/observing side uses master.
interface program_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_in;
    logic [31:0] mem_address;
    logic        mem_mode;
    logic [31:0] mem_data;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] words_written;

    modport slave (
        input  byte_valid, byte_in,
        output mem_address, mem_mode, mem_data, busy, done, error, words_written
    );

    modport master (
        output byte_valid, byte_in,
        input  mem_address, mem_mode, mem_data, busy, done, error, words_written
    );
endinterface

// File: rtl/program_loader.sv
// Framed byte-stream boot loader: SYNC, 4-byte BE word count, BE payload words, XOR checksum.
// Owns the memory write port and emits one single-cycle write per assembled word.
module program_loader #(
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter int unsigned MAX_WORDS = 4016,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input logic             clock,
    input logic             reset,
    program_loader_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StLen, StData, StCsum, StError} state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] len_q, len_d;
    logic [23:0] word_q, word_d;
    logic [7:0]  csum_q, csum_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        mode_q, mode_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [31:0] words_q, words_d;

    logic        valid;
    logic [7:0]  din;
    logic [31:0] len_next;
    logic [31:0] word_full;

    assign valid     = bus.byte_valid;
    assign din       = bus.byte_in;
    assign len_next  = {len_q[23:0], din};
    assign word_full = {word_q, din};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        word_d  = word_q;
        csum_d  = csum_q;
        addr_d  = addr_q;
        data_d  = data_q;
        mode_d  = 1'b0;
        busy_d  = busy_q;
        done_d  = done_q;
        error_d = error_q;
        words_d = words_q;

        case (state_q)
            StIdle, StError: begin
                if (valid && din == SYNC_BYTE) begin
                    state_d = StLen;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    words_d = 32'd0;
                    csum_d  = 8'd0;
                    cnt_d   = 2'd0;
                end
            end
            StLen: begin
                if (valid) begin
                    csum_d = csum_q ^ din;
                    len_d  = len_next;
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (len_next > 32'(MAX_WORDS)) begin
                            state_d = StError;
                            error_d = 1'b1;
                            busy_d  = 1'b0;
                        end else if (len_next == 32'd0) begin
                            state_d = StCsum;
                        end else begin
                            state_d = StData;
                        end
                    end
                end
            end
            StData: begin
                if (valid) begin
                    csum_d = csum_q ^ din;
                    word_d = word_full[23:0];
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        // Write registers are separate from assembly, so the next byte
                        // can be accepted during the write cycle.
                        data_d  = word_full;
                        addr_d  = BASE_ADDR + words_q;
                        mode_d  = 1'b1;
                        words_d = words_q + 32'd1;
                        if (words_q + 32'd1 == len_q) begin
                            state_d = StCsum;
                        end
                    end
                end
            end
            StCsum: begin
                if (valid) begin
                    busy_d = 1'b0;
                    if (din == csum_q) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StError;
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
            len_q   <= 32'd0;
            word_q  <= 24'd0;
            csum_q  <= 8'd0;
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            words_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            word_q  <= word_d;
            csum_q  <= csum_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            words_q <= words_d;
        end
    end

    assign bus.mem_address   = addr_q;
    assign bus.mem_mode      = mode_q;
    assign bus.mem_data      = data_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.error         = error_q;
    assign bus.words_written = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: frame-level reference model plus an attached
// flip-flop memory, checked every cycle, with literal expectations for directed frames.
module tb_program_loader;

    localparam logic [31:0] BaseAddr = 32'd0;
    localparam int unsigned MaxWords = 4016;
    localparam logic [7:0]  SyncByte = 8'hA5;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    program_loader_if bus();

    program_loader #(
        .BASE_ADDR (BaseAddr),
        .MAX_WORDS (MaxWords),
        .SYNC_BYTE (SyncByte)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [31:0] mem     [0:4095];
    logic [31:0] exp_mem [0:4095];
    int          wlog[$];

    // Memory captures at the posedge after the write cycle.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (bus.mem_mode) mem[bus.mem_address[11:0]] <= bus.mem_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a frame is the list of bytes received since SYNC; every output
    // follows from the frame length and its byte positions.
    logic        m_open = 1'b0;
    logic [7:0]  fq[$];
    longint      m_n = 0;
    logic        m_busy = 0, m_done = 0, m_err = 0, m_mode = 0;
    logic [31:0] m_ww = 0, m_addr = 0, m_data = 0;

    always @(posedge clock) begin
        logic [7:0]  b;
        logic [7:0]  cs;
        longint      k;
        m_mode = 1'b0;
        if (reset) begin
            m_open = 0; fq.delete(); m_n = 0;
            m_busy = 0; m_done = 0; m_err = 0; m_ww = 0; m_addr = 0; m_data = 0;
        end else if (bus.byte_valid) begin
            b = bus.byte_in;
            if (!m_open) begin
                if (b == SyncByte) begin
                    m_open = 1; fq.delete();
                    m_busy = 1; m_done = 0; m_err = 0; m_ww = 0;
                end
            end else begin
                fq.push_back(b);
                k = fq.size();
                if (k == 4) begin
                    m_n = longint'({fq[0], fq[1], fq[2], fq[3]});
                    if (m_n > MaxWords) begin
                        m_err = 1; m_busy = 0; m_open = 0;
                    end
                end else if (k > 4 && k <= 4 + 4 * m_n) begin
                    if ((k - 4) % 4 == 0) begin
                        m_data = {fq[k-4], fq[k-3], fq[k-2], fq[k-1]};
                        m_addr = BaseAddr + 32'((k - 4) / 4 - 1);
                        m_ww   = 32'((k - 4) / 4);
                        m_mode = 1;
                        exp_mem[m_addr[11:0]] = m_data;
                    end
                end else if (k == 5 + 4 * m_n) begin
                    cs = 8'd0;
                    for (int i = 0; i < k - 1; i++) cs ^= fq[i];
                    if (cs == b) m_done = 1; else m_err = 1;
                    m_busy = 0; m_open = 0;
                end
            end
        end
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge clock) begin
        if (bus.mem_mode) wlog.push_back(cyc);
        check("busy", 32'(bus.busy), 32'(m_busy));
        check("done", 32'(bus.done), 32'(m_done));
        check("error", 32'(bus.error), 32'(m_err));
        check("mem_mode", 32'(bus.mem_mode), 32'(m_mode));
        check("words_written", bus.words_written, m_ww);
        check("mem_address", bus.mem_address, m_addr);
        check("mem_data", bus.mem_data, m_data);
    end

    logic [7:0]  tx[$];
    logic [31:0] pay[$];

    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap) begin
            bus.byte_valid = 1'b0;
            @(negedge clock);
        end
        bus.byte_valid = 1'b1;
        bus.byte_in    = b;
        @(negedge clock);
        bus.byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.byte_valid = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    // Builds SYNC + length + payload + checksum from pay[] into tx[].
    task automatic build(input logic [31:0] n, input logic [7:0] corrupt);
        logic [7:0] cs;
        tx.delete();
        tx.push_back(SyncByte);
        for (int i = 3; i >= 0; i--) tx.push_back(n[8*i +: 8]);
        for (int w = 0; w < int'(n); w++)
            for (int i = 3; i >= 0; i--) tx.push_back(pay[w][8*i +: 8]);
        cs = 8'd0;
        for (int i = 1; i < tx.size(); i++) cs ^= tx[i];
        tx.push_back(cs ^ corrupt);
    endtask

    task automatic send_tx(input int max_gap);
        foreach (tx[i]) send(tx[i], $urandom_range(0, max_gap));
    endtask

    task automatic noise(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == SyncByte) b = 8'h5A;
            send(b, $urandom_range(0, 2));
        end
    endtask

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'h00;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset words", bus.words_written, 32'd0);

        // Two-word frame with correct checksum, no gaps.
        pay = '{32'hDEADBEEF, 32'h12345678};
        build(32'd2, 8'h00);
        check("lit checksum", 32'(tx[13]), 32'(8'h02 ^ 8'h00 ^ 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF
                                             ^ 8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78));
        wlog.delete();
        send_tx(0);
        idle(2);
        check("f1 done", 32'(bus.done), 32'd1);
        check("f1 words", bus.words_written, 32'd2);
        check("f1 mem0", mem[0], 32'hDEADBEEF);
        check("f1 mem1", mem[1], 32'h12345678);
        check("f1 writes", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) check("f1 spacing", 32'(wlog[1] - wlog[0]), 32'd4);

        // Corrupted checksum, then a good one-word frame.
        build(32'd2, 8'h40);
        send_tx(0);
        idle(2);
        check("bad error", 32'(bus.error), 32'd1);
        check("bad done", 32'(bus.done), 32'd0);
        pay = '{32'hCAFEF00D};
        build(32'd1, 8'h00);
        send_tx(1);
        idle(2);
        check("rec done", 32'(bus.done), 32'd1);
        check("rec error", 32'(bus.error), 32'd0);
        check("rec mem0", mem[0], 32'hCAFEF00D);

        // Oversized length: error right after the 4th length byte, no writes.
        wlog.delete();
        send(SyncByte, 0); send(8'h00, 0); send(8'h00, 0); send(8'h0F, 0); send(8'hB1, 0);
        check("big error", 32'(bus.error), 32'd1);
        check("big busy", 32'(bus.busy), 32'd0);
        noise(6);
        check("big writes", 32'(wlog.size()), 32'd0);

        // Empty frame, then a payload made of SYNC-valued bytes.
        send(SyncByte, 0); for (int i = 0; i < 5; i++) send(8'h00, 0);
        check("n0 done", 32'(bus.done), 32'd1);
        check("n0 words", bus.words_written, 32'd0);
        pay = '{32'hA5A5A5A5};
        build(32'd1, 8'h00);
        send_tx(0);
        idle(2);
        check("a5 mem0", mem[0], 32'hA5A5A5A5);
        check("a5 done", 32'(bus.done), 32'd1);

        // 16 random words with random gaps.
        pay.delete();
        for (int i = 0; i < 16; i++) pay.push_back($urandom());
        build(32'd16, 8'h00);
        send_tx(3);
        idle(2);
        check("r16 done", 32'(bus.done), 32'd1);
        for (int i = 0; i < 16; i++) check("r16 mem", mem[i], pay[i]);

        // Random frames, some corrupted, with noise in between.
        for (int f = 0; f < 12; f++) begin
            int n;
            n = $urandom_range(1, 6);
            pay.delete();
            for (int i = 0; i < n; i++) pay.push_back($urandom());
            build(32'(n), ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
            send_tx(2);
            noise($urandom_range(0, 4));
        end

        // Reset after two of three words.
        pay = '{32'h11112222, 32'h33334444, 32'h55556666};
        build(32'd3, 8'h00);
        for (int i = 0; i < 13; i++) send(tx[i], $urandom_range(0, 1));
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst words", bus.words_written, 32'd0);
        check("rst addr", bus.mem_address, 32'd0);
        noise(8);
        check("rst idle busy", 32'(bus.busy), 32'd0);
        check("rst mem0", mem[0], 32'h11112222);
        check("rst mem1", mem[1], 32'h33334444);

        idle(2);
        for (int i = 0; i < 32; i++) check("final mem", mem[i], exp_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-stream boot loader that sits directly upstream of the flip-flop instruction/data memory and owns that memory's write port.
- Receives a framed program image one byte per cycle, typically from the UART receiver.
- Assembles big-endian 32-bit words and writes them sequentially into memory starting at BASE_ADDR.
- Holds the CPU off the memory bus while loading and reports completion or error.

Parameters:
BASE_ADDR, 0, memory word address that receives payload word 0
MAX_WORDS, 4016, largest accepted word count; matches the memory SIZE
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clock  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
byte_valid  input  1  byte_in is valid this cycle; always accepted, no backpressure
byte_in  input  8  received byte
mem_address  output  32  memory address_in drive
mem_mode  output  1  memory mode drive; 1 = write, 0 = read
mem_data  output  32  memory data_in drive
busy  output  1  load in progress; CPU must not access memory while high
done  output  1  level; last frame loaded and checksum matched
error  output  1  level; last frame rejected
words_written  output  32  number of payload words written in the current/last frame

Behaviour:
Frame format:
- SYNC_BYTE, then 4 length bytes N (big-endian word count), then 4*N payload bytes (big-endian words), then 1 checksum byte.
- Checksum = XOR of all length and payload bytes.

Reset (synchronous):
- State IDLE.
- mem_address=0, mem_mode=0, mem_data=0, busy=0, done=0, error=0, words_written=0.
- Byte counters and checksum accumulator cleared.
- Reset mid-frame abandons the frame; any words already written stay in memory.

States:
- IDLE: a byte equal to SYNC_BYTE moves to LEN and sets busy=1, clears done, error, words_written and the checksum. Other bytes are ignored.
- LEN: shift in 4 bytes MSB first and fold each into the checksum. After the 4th byte:
  - N > MAX_WORDS -> ERROR.
  - N == 0 -> CSUM.
  - Otherwise -> DATA.
- DATA: shift bytes into the word register, MSB first, and fold each into the checksum. On the posedge that accepts the 4th byte of a word:
  - mem_data <= assembled word, mem_address <= BASE_ADDR + words_written, mem_mode <= 1 for exactly one cycle.
  - The memory captures the word at the following posedge.
  - words_written increments together with mem_mode rising.
  - After word N-1 -> CSUM.
  - SYNC_BYTE values inside DATA are payload, not resync.
- CSUM: the next valid byte is compared with the accumulator.
  - Equal -> IDLE, done=1, busy=0.
  - Unequal -> ERROR.
- ERROR: error=1, busy=0, mem_mode=0. A SYNC_BYTE restarts as from IDLE (clears error); other bytes are ignored.

Timing and bus rules:
- mem_mode is 0 in every cycle except the single write cycle per word.
- mem_address and mem_data hold their last values between writes.
- Throughput is one byte per cycle with no stalls.
- A byte arriving in the write cycle is accepted normally; the write registers are separate from the assembly register.
- byte_valid=0 cycles insert gaps anywhere and change no state.
- Address arithmetic is 32-bit unsigned; no wrap is possible since N <= MAX_WORDS.
- done and error are mutually exclusive; busy is never high together with either.

Test Plan:
- Frame A5 00 00 00 02 DE AD BE EF 12 34 56 78 with correct checksum -> writes 0xDEADBEEF at addr 0 and 0x12345678 at addr 1, each with mem_mode high exactly one cycle, 4 cycles apart; done=1, words_written=2, memory reads back both.
- Same frame with checksum byte corrupted -> both words written, error=1, done=0; a following valid 1-word frame clears error and ends done=1.
- Length 0x00000FB1 (4017 > 4016) -> error=1 right after the 4th length byte, mem_mode never asserted.
- N=0 frame A5 00 00 00 00 00 -> done=1, no writes; N=1 payload A5 A5 A5 A5 -> written as 0xA5A5A5A5, not treated as resync.
- Random byte_valid gaps (0-3 idle cycles) during a 16-word frame -> identical memory contents and done=1.
- reset asserted after 2 of 3 words -> all outputs return to reset values next cycle; subsequent bytes ignored until SYNC_BYTE; words 0-1 remain in memory.
